psum_requant: RTL and testbench
===============================

# psum_requant

Downstream neighbour of the vector-multiply stage. Accumulates a programmable number of signed dot-product partial sums into one result, adds a bias, rounds and shifts, applies optional ReLU, and saturates to the activation width. Results go into a small output FIFO with a valid/ready interface. The upstream stage has no backpressure, so this block accepts a partial on every cycle and flags any result that it must drop.

## Interface
- W_Y, 19: width of signed input partial sum (matches upstream W_X+W_K+clog2(C)).
- W_ACC, 32: accumulator and bias width, signed.
- W_OUT, 8: output activation width, signed.
- FIFO_DEPTH, 4: output FIFO entries, power of two ≥ 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  partial-sum strobe; driven by upstream v_valid.
- s_data  in  W_Y  signed partial sum.
- cfg_len  in  8  partials per result; 0 is treated as 1.
- cfg_bias  in  W_ACC  signed bias.
- cfg_shift  in  5  arithmetic right shift amount, 0..31.
- cfg_relu  in  1  1 = clamp negatives to 0.
- flush  in  1  synchronous abort of the in-progress group and the pipeline; FIFO is kept.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts the head entry.
- m_data  out  W_OUT  signed FIFO head.
- err_ovf  out  1  sticky; a result was dropped because the FIFO was full.

## Operation
- Group counter cnt runs 0..len-1. On s_valid with cnt==0, latch cfg_len/bias/shift/relu into shadow registers. Config changes mid-group are ignored.
- Accumulate: s_data is sign-extended to W_ACC. acc wraps modulo 2^W_ACC; there is no saturation inside the accumulator.
- Group states:
  - IDLE (cnt==0): s_valid moves to ACC with acc = s_data, or goes straight to FINAL if len==1.
  - ACC: each s_valid adds s_data and increments cnt.
  - The partial where cnt==len-1 triggers FINAL; cnt returns to 0 and acc clears on the same edge.
- Stage A (edge closing the last-partial cycle): fsum = acc + s_data + bias, in W_ACC+1 bits.
- Stage B (next edge):
  - r = shift==0 ? fsum : (fsum + 2^(shift-1)) >>> shift. This is round-half-up.
  - If relu and r<0, then r = 0.
  - Saturate r to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - Push the result into the FIFO.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - If it is full with no pop, the result is dropped and err_ovf is set. err_ovf clears only on reset.
- m_data shows the head entry while m_valid=1; its value is don't-care when empty. A pop happens on m_valid&&m_ready.
- flush:
  - Clears cnt, acc, and the stage A/B valids on the next edge; in-flight results are discarded.
  - If flush and s_valid occur in the same cycle, flush wins and that partial is discarded.
  - FIFO contents and err_ovf are unaffected.
- Reset values: m_valid=0, m_data=0, err_ovf=0. cnt, acc, pipeline valids, FIFO pointers and shadow config are all 0.
- Asserting rstn low mid-group discards all state immediately.

## Timing
- The block accepts one partial per cycle indefinitely, including a new group starting on the cycle after a last partial.
- Latency: last partial sampled in cycle t gives a FIFO write at the end of t+1, so m_valid=1 in cycle t+2 if the FIFO was empty.
- With len=1 and m_ready held high, throughput is one result per cycle.
- m_valid and m_data are registered (FIFO outputs); there is no combinational path from m_ready to m_valid.
- The pipeline does not stall on FIFO full; the block drops the result instead.

## Test plan
- Basic group: len=3, bias=10, shift=2, relu=0; partials 100, 200, -50 on consecutive cycles. Required: m_data=65 ((260+2)>>>2), m_valid rises 2 cycles after the third partial.
- Saturation and ReLU with len=1, shift=0:
  - s_data=1000 gives 127.
  - s_data=-300 with relu=0 gives -128.
  - s_data=-300 with relu=1 gives 0.
- Rounding with shift=1, bias=0, len=1: fsum 3 gives 2, fsum -3 gives -1, fsum 1 gives 1.
- Backpressure: m_ready=0, five len=1 groups with values 1..5. Required: 4 entries held, value 5 dropped, err_ovf=1. Then m_ready=1 drains 1,2,3,4 in order and err_ovf stays 1.
- Config and boundaries:
  - cfg_len=0 behaves as len=1.
  - Changing cfg_shift after the first partial of a len=4 group does not affect that group.
  - Back-to-back len=2 groups produce results every 2 cycles with no lost partial.
- Abort: flush one cycle after the 2nd partial of a len=4 group, then a fresh group of 4 ones with bias 0 and shift 0. Required: single output 4, no stale result. Asserting rstn low mid-group clears m_valid and err_ovf at once.

Source files
------------

// File: rtl/psum_requant.sv
// Partial-sum requantizer: groups signed partials, adds bias, rounds/shifts,
// optional ReLU, saturates to W_OUT and queues results in a small output FIFO.
module psum_requant #(
   parameter int W_Y        = 19,
   parameter int W_ACC      = 32,
   parameter int W_OUT      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             s_valid,
   input  logic [W_Y-1:0]   s_data,
   input  logic [7:0]       cfg_len,
   input  logic [W_ACC-1:0] cfg_bias,
   input  logic [4:0]       cfg_shift,
   input  logic             cfg_relu,
   input  logic             flush,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [W_OUT-1:0] m_data,
   output logic             err_ovf
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int W_F = W_ACC + 1;
   localparam int W_R = W_ACC + 2;
   localparam logic signed [W_R-1:0] OUT_MAX = W_R'((2 ** (W_OUT - 1)) - 1);
   localparam logic signed [W_R-1:0] OUT_MIN = -OUT_MAX - W_R'(1);

   typedef struct packed {
      logic signed [W_F-1:0] fsum;
      logic [4:0]            shift;
      logic                  relu;
   } stage_a_t;

   // ---------------- group accumulation ----------------
   logic [7:0]            cnt, sh_len, len_eff;
   logic [W_ACC-1:0]      acc, sh_bias, bias_eff, s_ext;
   logic [4:0]            sh_shift, shift_eff;
   logic                  sh_relu, relu_eff;
   logic                  idle, last, fire;
   logic signed [W_F-1:0] fsum;

   assign s_ext = {{(W_ACC - W_Y){s_data[W_Y-1]}}, s_data};

   // The first partial of a group sees live config; later ones see the shadow copy.
   always_comb begin
      idle      = (cnt == 8'd0);
      len_eff   = idle ? ((cfg_len == 8'd0) ? 8'd1 : cfg_len) : sh_len;
      bias_eff  = idle ? cfg_bias  : sh_bias;
      shift_eff = idle ? cfg_shift : sh_shift;
      relu_eff  = idle ? cfg_relu  : sh_relu;
      last      = (cnt == len_eff - 8'd1);
      fire      = s_valid && !flush && last;
      fsum      = $signed({acc[W_ACC-1], acc})
                + $signed({s_ext[W_ACC-1], s_ext})
                + $signed({bias_eff[W_ACC-1], bias_eff});
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt      <= '0;
         acc      <= '0;
         sh_len   <= '0;
         sh_bias  <= '0;
         sh_shift <= '0;
         sh_relu  <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
         acc <= '0;
      end else if (s_valid) begin
         if (idle) begin
            sh_len   <= len_eff;
            sh_bias  <= cfg_bias;
            sh_shift <= cfg_shift;
            sh_relu  <= cfg_relu;
         end
         if (last) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + 8'd1;
            acc <= acc + s_ext;
         end
      end
   end

   // ---------------- stage A: registered final sum ----------------
   stage_a_t sa;
   logic     a_vld;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_vld <= 1'b0;
         sa    <= '0;
      end else begin
         a_vld <= fire;
         if (fire) begin
            sa.fsum  <= fsum;
            sa.shift <= shift_eff;
            sa.relu  <= relu_eff;
         end
      end
   end

   // ---------------- stage B: round, relu, saturate ----------------
   logic signed [W_R-1:0] f_ext, rnd, r;
   logic [W_OUT-1:0]      res;
   logic                  push;

   // One extra bit of headroom so the rounding increment cannot overflow.
   always_comb begin
      f_ext = {sa.fsum[W_F-1], sa.fsum};
      rnd   = f_ext;
      if (sa.shift != 5'd0)
         rnd = (f_ext + (W_R'(1) <<< (sa.shift - 5'd1))) >>> sa.shift;
      r = rnd;
      if (sa.relu && r[W_R-1])
         r = '0;
      if (r > OUT_MAX)
         res = OUT_MAX[W_OUT-1:0];
      else if (r < OUT_MIN)
         res = OUT_MIN[W_OUT-1:0];
      else
         res = r[W_OUT-1:0];
      push = a_vld && !flush;
   end

   // ---------------- output FIFO ----------------
   logic [W_OUT-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             full, pop, wr;

   assign full    = (count == (AW + 1)'(FIFO_DEPTH));
   assign pop     = m_valid && m_ready;
   assign wr      = push && (!full || pop);
   assign m_valid = (count != '0);
   assign m_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= res;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr && !pop)
            count <= count + (AW + 1)'(1);
         else if (!wr && pop)
            count <= count - (AW + 1)'(1);
         if (push && !wr)
            err_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_psum_requant.sv
// Bench for psum_requant: directed scenarios plus randomized groups checked
// against an arithmetic reference of the requantization rules.
module tb_psum_requant;
   localparam int W_Y = 19, W_ACC = 32, W_OUT = 8, FIFO_DEPTH = 4;

   logic             clk = 1'b0, rstn = 1'b0;
   logic             s_valid = 1'b0, flush = 1'b0, m_ready = 1'b0, cfg_relu = 1'b0;
   logic [W_Y-1:0]   s_data = '0;
   logic [7:0]       cfg_len = '0;
   logic [W_ACC-1:0] cfg_bias = '0;
   logic [4:0]       cfg_shift = '0;
   logic             m_valid, err_ovf;
   logic [W_OUT-1:0] m_data;

   int  vecs = 0, errs = 0;
   int  got[$], exp_q[$];
   time gtime[$];

   psum_requant #(.W_Y(W_Y), .W_ACC(W_ACC), .W_OUT(W_OUT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .cfg_len(cfg_len),
      .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .flush(flush),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_ovf(err_ovf));

   always #5 clk = ~clk;

   // Record every accepted output, sampled mid-cycle.
   always @(negedge clk)
      if (m_valid && m_ready) begin
         got.push_back(int'($signed(m_data)));
         gtime.push_back($time);
      end

   // Reference: sum + bias, round half up by 2^shift, relu, clamp to 8-bit signed.
   function automatic int ref_out(longint sum, longint bias, int sh, bit relu);
      real    f;
      longint q;
      f = real'(sum + bias);
      q = longint'($floor(f / (2.0 ** sh) + 0.5));
      if (relu && q < 0) q = 0;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return int'(q);
   endfunction

   task automatic cyc(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_cfg(int len, int bias, int sh, bit relu);
      cfg_len = 8'(len); cfg_bias = 32'(bias); cfg_shift = 5'(sh); cfg_relu = relu;
   endtask

   task automatic part(int v);
      s_valid = 1'b1; s_data = W_Y'(v);
      cyc(1);
      s_valid = 1'b0;
   endtask

   task automatic drain();
      m_ready = 1'b1; cyc(FIFO_DEPTH + 4); m_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
      vecs++; if (m_data !== '0) begin errs++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
      vecs++; if (err_ovf !== 1'b0) begin errs++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf); end
      cyc(2); rstn = 1'b1; cyc(1);
   endtask

   task automatic test_basic();
      got.delete();
      set_cfg(3, 10, 2, 0);
      part(100); part(200); part(-50);
      vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid: got %b want 0", m_valid); end
      cyc(1);
      vecs++; if (m_valid !== 1'b1) begin errs++; $display("FAIL basic_latency_valid: got %b want 1", m_valid); end
      vecs++; if ($signed(m_data) !== 8'sd65) begin errs++; $display("FAIL basic_data: got %0d want 65", $signed(m_data)); end
      drain();
      vecs++; if (got.size() != 1) begin errs++; $display("FAIL basic_count: got %0d want 1", got.size()); end
   endtask

   task automatic test_sat_relu();
      got.delete(); exp_q = '{127, -128, 0};
      set_cfg(1, 0, 0, 0); part(1000);
      part(-300);
      cfg_relu = 1'b1; part(-300);
      drain();
      vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL sat_count: got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vecs++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
   endtask

   task automatic test_rounding();
      got.delete(); exp_q = '{2, -1, 1};
      set_cfg(1, 0, 1, 0);
      part(3); part(-3); part(1);
      drain();
      vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL round_count: got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vecs++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL round_data[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      got.delete(); exp_q = '{1, 2, 3, 4};
      m_ready = 1'b0; set_cfg(1, 0, 0, 0);
      for (int v = 1; v <= 5; v++) part(v);
      vecs++; if (err_ovf !== 1'b0) begin errs++; $display("FAIL bp_ovf_early: got %b want 0", err_ovf); end
      cyc(1);
      vecs++; if (err_ovf !== 1'b1) begin errs++; $display("FAIL bp_ovf_set: got %b want 1", err_ovf); end
      drain();
      vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vecs++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
      vecs++; if (err_ovf !== 1'b1) begin errs++; $display("FAIL bp_ovf_sticky: got %b want 1", err_ovf); end
   endtask

   task automatic test_config();
      got.delete(); exp_q = '{7, 9, -25};
      set_cfg(0, 0, 0, 0); part(7); part(9);
      set_cfg(4, 0, 2, 0); part(-10);
      set_cfg(1, 100, 0, 1);
      part(-20); part(-30); part(-40);
      drain();
      vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL cfg_count: got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vecs++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL cfg_data[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int a, b;
      for (int len = 2; len >= 1; len--) begin
         got.delete(); gtime.delete(); exp_q.delete();
         set_cfg(len, 3, 1, 0); m_ready = 1'b1;
         for (int g = 0; g < 6; g++) begin
            a = int'($urandom_range(0, 200)) - 100;
            b = (len == 2) ? int'($urandom_range(0, 200)) - 100 : 0;
            exp_q.push_back(ref_out(a + b, 3, 1, 0));
            part(a);
            if (len == 2) part(b);
         end
         cyc(4); m_ready = 1'b0;
         vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL b2b_len%0d_count: got %0d want %0d", len, got.size(), exp_q.size()); end
         foreach (exp_q[i]) begin
            vecs++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL b2b_len%0d_data[%0d]: got %0d want %0d", len, i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
         end
         for (int i = 1; i < gtime.size(); i++) begin
            vecs++;
            if (gtime[i] - gtime[i-1] != time'(10 * len)) begin errs++; $display("FAIL b2b_len%0d_spacing[%0d]: got %0t want %0d", len, i, gtime[i] - gtime[i-1], 10 * len); end
         end
      end
   endtask

   task automatic test_flush();
      got.delete(); exp_q = '{4, 7};
      m_ready = 1'b0; set_cfg(4, 0, 0, 0);
      part(5); part(6);
      flush = 1'b1; cyc(1); flush = 1'b0;
      for (int i = 0; i < 4; i++) part(1);
      cyc(2);
      vecs++; if (m_valid !== 1'b1 || $signed(m_data) !== 8'sd4) begin errs++; $display("FAIL flush_head: got v=%b d=%0d want v=1 d=4", m_valid, $signed(m_data)); end
      set_cfg(2, 0, 0, 0); part(50);
      s_valid = 1'b1; s_data = W_Y'(60); flush = 1'b1; cyc(1); s_valid = 1'b0; flush = 1'b0;
      part(3); part(4);
      set_cfg(1, 0, 0, 0); part(99);
      flush = 1'b1; cyc(1); flush = 1'b0;
      cyc(2); drain();
      vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL flush_count: got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vecs++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL flush_data[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
   endtask

   task automatic test_random();
      int     d, b, sh, mcnt, mlen, mb, msh;
      bit     rl, mrl;
      longint msum;
      got.delete(); exp_q.delete();
      mcnt = 0; msum = 0; mlen = 1; mb = 0; msh = 0; mrl = 0;
      m_ready = 1'b1;
      for (int c = 0; c < 400; c++) begin
         b  = int'($urandom_range(0, 4000)) - 2000;
         sh = int'($urandom_range(0, 16));
         rl = 1'($urandom_range(0, 1));
         set_cfg(int'($urandom_range(0, 5)), b, sh, rl);
         // keep the trailing group closable: only stop sending once it completes
         if ($urandom_range(0, 3) != 0 || (c >= 390 && mcnt != 0)) begin
            d = int'($urandom_range(0, 400000)) - 200000;
            if (mcnt == 0) begin
               mlen = (cfg_len == 8'd0) ? 1 : int'(cfg_len);
               mb = b; msh = sh; mrl = rl;
            end
            msum += d; mcnt++;
            if (mcnt == mlen) begin
               exp_q.push_back(ref_out(msum, mb, msh, mrl));
               mcnt = 0; msum = 0;
            end
            s_valid = 1'b1; s_data = W_Y'(d);
         end else s_valid = 1'b0;
         cyc(1);
      end
      s_valid = 1'b0;
      for (int k = 0; k < 8 && mcnt != 0; k++) begin
         d = int'($urandom_range(0, 1000)) - 500;
         msum += d; mcnt++;
         if (mcnt == mlen) begin
            exp_q.push_back(ref_out(msum, mb, msh, mrl));
            mcnt = 0; msum = 0;
         end
         part(d);
      end
      cyc(4); drain();
      vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vecs++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL rand_data[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
   endtask

   task automatic test_reset_midgroup();
      got.delete(); exp_q = '{30};
      m_ready = 1'b0; set_cfg(1, 0, 0, 0);
      for (int v = 1; v <= 6; v++) part(v);
      cyc(2);
      vecs++; if (err_ovf !== 1'b1 || m_valid !== 1'b1) begin errs++; $display("FAIL rst_pre: got ovf=%b v=%b want 1 1", err_ovf, m_valid); end
      set_cfg(3, 0, 0, 0); part(1);
      rstn = 1'b0; #1;
      vecs++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_async_valid: got %b want 0", m_valid); end
      vecs++; if (err_ovf !== 1'b0) begin errs++; $display("FAIL rst_async_ovf: got %b want 0", err_ovf); end
      vecs++; if (m_data !== '0) begin errs++; $display("FAIL rst_async_data: got %0d want 0", m_data); end
      cyc(1); rstn = 1'b1;
      set_cfg(2, 0, 0, 0); part(10); part(20);
      cyc(2); drain();
      vecs++; if (got.size() != exp_q.size()) begin errs++; $display("FAIL rst_count: got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         vecs++;
         if (i >= got.size() || got[i] !== exp_q[i]) begin errs++; $display("FAIL rst_data[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -999, exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sat_relu();
      test_rounding();
      test_config();
      test_back_to_back();
      test_flush();
      test_random();
      test_backpressure();
      test_reset_midgroup();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
